// File: rtl/noc_pkg.sv
// Shared NoC link types: flit width, flit type and the sender's reset credit count.
// Imported by the link receiver, link sender and router stages.
package noc_pkg;
    localparam int FLIT_W       = 16;
    localparam int LINK_CREDITS = 4;

    typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/noc_link_rx_if.sv
// Link-side and router-side signals of the receive endpoint, bundled.
// slave: the receiver's view; master: the sender/router (or bench) view.
interface noc_link_rx_if #(
    parameter int FLIT_W = noc_pkg::FLIT_W
);
    logic              in_enable;
    logic [FLIT_W-1:0] in_data;
    logic              in_credit;
    logic              out_valid;
    logic [FLIT_W-1:0] out_data;
    logic              out_ready;
    logic              ovf_err;

    modport slave (
        input  in_enable, in_data, out_ready,
        output in_credit, out_valid, out_data, ovf_err
    );

    modport master (
        output in_enable, in_data, out_ready,
        input  in_credit, out_valid, out_data, ovf_err
    );
endinterface

// File: rtl/noc_rx_fifo.sv
// Generic DEPTH-entry first-word-fall-through FIFO; caller qualifies wr_en/rd_en.
// Latency: a write is visible on rd_dat the cycle after the edge if empty.
// Backpressure: none internally; full/empty are exported for the caller to gate.
module noc_rx_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_en,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_dat = mem[rd_ptr];
    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
endmodule

// File: rtl/noc_link_rx.sv
// Credit-flow-controlled NoC link receiver; optional flit counter under NOC_RX_STATS_EN.
// Latency: flit on link at edge N is on out_data after edge N if buffer empty; credit 1 cycle after pop.
// Backpressure: out_ready stalls the head; sender is held off by credits, excess flits set ovf_err.
module noc_link_rx
    import noc_pkg::*;
#(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = LINK_CREDITS
) (
    input  logic               clk,
    input  logic               rst,
    noc_link_rx_if.slave       lnk
`ifdef NOC_RX_STATS_EN
    ,
    output logic [31:0]        flit_cnt
`endif
);
    logic              pop;
    logic              push_ok;
    logic              drop;
    logic              full;
    logic              empty;
    logic [FLIT_W-1:0] head;
    logic              credit_q;
    logic              ovf_q;

    noc_rx_fifo #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (push_ok),
        .wr_dat (lnk.in_data),
        .rd_en  (pop),
        .rd_dat (head),
        .full   (full),
        .empty  (empty)
    );

    // A full buffer still takes a flit when the head leaves on the same edge.
    assign pop     = ~empty & lnk.out_ready;
    assign push_ok = lnk.in_enable & (~full | pop);
    assign drop    = lnk.in_enable & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            credit_q <= pop;
            ovf_q    <= ovf_q | drop;
        end
    end

`ifdef NOC_RX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_cnt <= '0;
        end else if (push_ok && (flit_cnt != 32'hFFFF_FFFF)) begin
            flit_cnt <= flit_cnt + 32'd1;
        end
    end
`endif

    assign lnk.in_credit = credit_q;
    assign lnk.ovf_err   = ovf_q;
    assign lnk.out_valid = ~empty;
    assign lnk.out_data  = head;
endmodule

// File: tb/tb_noc_link_rx.sv
// Bench for noc_link_rx: table-driven vectors plus a queue scoreboard of expected flits.
// Inputs change and outputs are sampled on the falling edge.
module tb_noc_link_rx;
    import noc_pkg::*;

    localparam int DEPTH = LINK_CREDITS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_link_rx_if #(.FLIT_W(FLIT_W)) lnk ();

`ifdef NOC_RX_STATS_EN
    logic [31:0] flit_cnt;
    noc_link_rx #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .lnk      (lnk.slave),
        .flit_cnt (flit_cnt)
    );
`else
    noc_link_rx #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .lnk (lnk.slave)
    );
`endif

    int    checks = 0;
    int    errors = 0;
    int    credit_seen = 0;
    flit_t q[$];
    logic  exp_credit = 1'b0;
    logic  exp_ovf = 1'b0;
    int    cnt_m = 0;

    typedef struct {
        logic  en;
        flit_t dat;
        logic  rdy;
        logic  exp_valid;
        flit_t exp_head;
        logic  exp_credit;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Check current outputs against the model, then drive one cycle of inputs.
    task automatic step(input logic en, input flit_t d, input logic rdy);
        logic pop;
        logic acc;
        chk("valid", {31'd0, lnk.out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) chk("sb_data", {16'd0, lnk.out_data}, {16'd0, q[0]});
        chk("credit", {31'd0, lnk.in_credit}, {31'd0, exp_credit});
        chk("ovf", {31'd0, lnk.ovf_err}, {31'd0, exp_ovf});
`ifdef NOC_RX_STATS_EN
        chk("flit_cnt", flit_cnt, cnt_m);
`endif
        if (lnk.in_credit) credit_seen++;
        lnk.in_enable = en;
        lnk.in_data   = d;
        lnk.out_ready = rdy;
        pop = (q.size() != 0) && rdy;
        acc = en && ((q.size() < DEPTH) || pop);
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(d);
            cnt_m++;
        end
        if (en && !acc) exp_ovf = 1'b1;
        exp_credit = pop;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete();
        exp_credit = 1'b0;
        exp_ovf    = 1'b0;
        cnt_m      = 0;
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        lnk.in_enable = 1'b0;
        lnk.out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                en    dat      rdy   valid head     credit
        vecs[0]  = '{1'b1, 16'hA5A5, 1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA5A5, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[4]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[5]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 16'h0001, 1'b0};
        vecs[6]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 16'h0001, 1'b0};
        vecs[7]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 16'h0001, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b1};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b1};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};

        lnk.in_enable = 1'b0;
        lnk.in_data   = '0;
        lnk.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, lnk.out_valid}, 32'd0);
        chk("rst_data", {16'd0, lnk.out_data}, 32'd0);
        chk("rst_credit", {31'd0, lnk.in_credit}, 32'd0);
        chk("rst_ovf", {31'd0, lnk.ovf_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single flit and fill/drain with explicit expected values.
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("vec%0d_valid", i), {31'd0, lnk.out_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_data", i), {16'd0, lnk.out_data}, {16'd0, vecs[i].exp_head});
            chk($sformatf("vec%0d_credit", i), {31'd0, lnk.in_credit}, {31'd0, vecs[i].exp_credit});
            step(vecs[i].en, vecs[i].dat, vecs[i].rdy);
        end

        // Overflow: full buffer, no pop, extra flit dropped.
        for (int i = 1; i <= 4; i++) step(1'b1, flit_t'(i), 1'b0);
        step(1'b1, 16'hDEAD, 1'b0);
        chk("ovf_set", {31'd0, lnk.ovf_err}, 32'd1);
        chk("ovf_no_credit", {31'd0, lnk.in_credit}, 32'd0);
        chk("ovf_head", {16'd0, lnk.out_data}, 32'h0001);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        repeat (2) step(1'b0, '0, 1'b0);
        chk("ovf_sticky", {31'd0, lnk.ovf_err}, 32'd1);

        // Reset asserted mid-cycle with flits buffered and a credit pending.
        step(1'b1, 16'h0007, 1'b0);
        step(1'b1, 16'h0008, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("pre_rst_credit", {31'd0, lnk.in_credit}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, lnk.out_valid}, 32'd0);
        chk("mid_rst_data", {16'd0, lnk.out_data}, 32'd0);
        chk("mid_rst_credit", {31'd0, lnk.in_credit}, 32'd0);
        chk("mid_rst_ovf", {31'd0, lnk.ovf_err}, 32'd0);
        lnk.out_ready = 1'b0;
        lnk.in_enable = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, '0, 1'b0);
        chk("post_rst_valid", {31'd0, lnk.out_valid}, 32'd0);

        // Full buffer with simultaneous push and pop.
        sync_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, flit_t'(i), 1'b0);
        credit_seen = 0;
        step(1'b1, 16'h0005, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        repeat (2) step(1'b0, '0, 1'b0);
        chk("fullpp_ovf", {31'd0, lnk.ovf_err}, 32'd0);
        chk("fullpp_credits", credit_seen, 32'd5);

        // Random traffic against the scoreboard.
        sync_reset();
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), flit_t'($urandom), 1'($urandom_range(0, 1)));

`ifdef NOC_RX_STATS_EN
        sync_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, flit_t'(i), 1'b0);
        step(1'b1, 16'hDEAD, 1'b0);
        for (int i = 5; i <= 10; i++) step(1'b1, flit_t'(i), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        chk("stats_ten", flit_cnt, 32'd10);
        rst = 1'b1;
        #1;
        chk("stats_rst", flit_cnt, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
